// File: rtl/inst_enc32.sv
// inst_enc32: two-stage RV32I encoder turning decoded fields plus an immediate into a packed word.
// Define IMM_RANGE_CHECK_EN to enable immediate range checking (out_err, err_cnt).
module inst_enc32 #(
  parameter int INSTWIDTH = 32,
  parameter int DATAWIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [6:0]                  in_opcode,
  input  logic [4:0]                  in_rd,
  input  logic [4:0]                  in_rs1,
  input  logic [4:0]                  in_rs2,
  input  logic [2:0]                  in_funct3,
  input  logic [6:0]                  in_funct7,
  input  logic signed [DATAWIDTH-1:0] in_imm,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTWIDTH-1:0]        out_inst,
  output logic                        out_err,
  output logic [7:0]                  err_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPRI   = 7'b0010011;

  function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
    return (op == OP_OPRI) && ((f3 == 3'b001) || (f3 == 3'b101));
  endfunction

  function automatic logic [31:0] pack(
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    case (op)
      OP_LUI, OP_AUIPC: w = {imm[31:12], rd, op};
      OP_JAL:           w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      OP_JALR, OP_LOAD: w = {imm[11:0], rs1, f3, rd, op};
      OP_OPRI:          w = is_shift(op, f3) ? {f7, imm[4:0], rs1, f3, rd, op}
                                             : {imm[11:0], rs1, f3, rd, op};
      OP_STORE:         w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      OP_BRANCH:        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      default:          w = {f7, rs2, rs1, f3, rd, op};
    endcase
    return w;
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  function automatic logic imm_bad(
    input logic [6:0]                  op,
    input logic [2:0]                  f3,
    input logic signed [DATAWIDTH-1:0] imm
  );
    logic bad;
    case (op)
      OP_LUI, OP_AUIPC: bad = (imm[11:0] != 12'd0);
      OP_JAL:           bad = (imm < -1048576) || (imm > 1048574) || imm[0];
      OP_BRANCH:        bad = (imm < -4096) || (imm > 4094) || imm[0];
      OP_JALR, OP_LOAD, OP_STORE: bad = (imm < -2048) || (imm > 2047);
      OP_OPRI:          bad = is_shift(op, f3) ? ((imm < 0) || (imm > 31))
                                               : ((imm < -2048) || (imm > 2047));
      default:          bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  logic                        vld_p1;
  logic [6:0]                  op_p1;
  logic [4:0]                  rd_p1, rs1_p1, rs2_p1;
  logic [2:0]                  f3_p1;
  logic [6:0]                  f7_p1;
  logic signed [DATAWIDTH-1:0] imm_p1;
  logic [31:0]                 word_p1;
  logic                        err_p1;
  logic                        s2_free, in_fire;

  // S2 can take a word when empty or when its current word leaves this cycle
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_free;
  assign in_fire  = in_valid && in_ready;

  // ---- stage 1: capture request fields ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_p1 <= 1'b0;
    else if (in_fire) vld_p1 <= 1'b1;
    else if (s2_free) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      op_p1  <= in_opcode;
      rd_p1  <= in_rd;
      rs1_p1 <= in_rs1;
      rs2_p1 <= in_rs2;
      f3_p1  <= in_funct3;
      f7_p1  <= in_funct7;
      imm_p1 <= in_imm;
    end
  end

  assign word_p1 = pack(op_p1, rd_p1, rs1_p1, rs2_p1, f3_p1, f7_p1, imm_p1[31:0]);
`ifdef IMM_RANGE_CHECK_EN
  assign err_p1 = imm_bad(op_p1, f3_p1, imm_p1);
`else
  assign err_p1 = 1'b0;
`endif

  // ---- stage 2: registered packed word and error flag ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else if (s2_free) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_inst <= INSTWIDTH'(word_p1);
        out_err  <= err_p1;
      end
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= 8'd0;
    else if (out_valid && out_ready && out_err && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: doc/inst_enc32.md
# inst_enc32

Pipelined RV32I instruction encoder: the inverse of the decode-side immediate generator. It accepts decoded instruction fields (opcode, register indices, funct codes, 32-bit signed immediate) over a valid/ready handshake and emits the packed 32-bit instruction word two cycles later. It also flags immediates that the selected format cannot represent. It sits between the test/boot-image sequencer and the instruction memory write port, and is used to build programs on-chip and to round-trip check the decoder.

## Interface
- INSTWIDTH (`INSTWIDTH from RV32I.h), 32: output word width.
- DATAWIDTH (`DATAWIDTH), 32: immediate input width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request fields valid.
- in_ready  out  1  encoder can accept this cycle.
- in_opcode  in  7  ir[6:0] value; `LUI/`AUIPC/`JAL/`JALR/`BRANCH/`LOAD/`STORE/`OPRI, anything else is R-type.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3;  in_funct7  in  7.
- in_imm  in  DATAWIDTH  signed byte immediate (U-type: full value with low 12 bits expected zero).
- out_valid  out  1  out_inst valid.
- out_ready  in  1  consumer accepts.
- out_inst  out  INSTWIDTH  encoded word.
- out_err  out  1  immediate not representable; qualifies out_inst.
- err_cnt  out  8  saturating count of delivered words with out_err=1.

## Operation
- Stage S1 registers all input fields on in_valid && in_ready; computes format and range check combinationally into S1 result.
- Stage S2 registers the packed word and error bit; drives out_*.
- Packing (fields unused by a format ignored):
  - U (LUI, AUIPC): {imm[31:12], rd, op}.
  - J (JAL): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - I (JALR, LOAD, OPRI): {imm[11:0], rs1, funct3, rd, op}; OPRI with funct3 001/101 (shifts): {funct7, imm[4:0], rs1, funct3, rd, op}.
  - S (STORE): {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B (BRANCH): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - default (R): {funct7, rs2, rs1, funct3, rd, op}; imm ignored, never errors.
- Range rules (out_err=1 when violated; word still emitted with truncated fields):
  - I, S: -2048..2047. Shift-OPRI: 0..31.
  - B: -4096..4094, imm[0]=0. J: -1048576..1048574, imm[0]=0.
  - U: imm[11:0]=0.
- err_cnt increments on out_valid && out_ready && out_err; saturates at 255.

## Timing
- Reset: out_valid=0, out_inst=0, out_err=0, err_cnt=0, both stages empty; in_ready=1 the first cycle after reset deasserts.
- Latency: 2 cycles from input acceptance edge to out_valid. Throughput: 1 word/cycle while out_ready=1.
- s2_free = !out_valid || out_ready; in_ready = !s1_valid || s2_free (combinational through from out_ready; no bubble when draining).
- While out_valid && !out_ready: out_inst, out_err stable; S1 holds; in_ready=0 once S1 full.
- Simultaneous accept at input and drain at output in one cycle: both take effect, no loss or duplication.
- Reset mid-stream: both stages flushed immediately (async); in-flight words dropped, err_cnt cleared.

## Configuration
- IMM_RANGE_CHECK_EN defined: range rules above active, out_err and err_cnt live.
- Not defined: no range logic; out_err tied 0, err_cnt tied 0; packing and truncation unchanged.

## Test plan
- ADDI: op=`OPRI, rd=1, rs1=0, funct3=0, imm=5 -> out_inst=0x00500093, out_err=0, 2 cycles after accept.
- JAL rd=1 imm=8 -> 0x008000EF; BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; LUI rd=5 imm=0x12345000 -> 0x123452B7.
- ADDI rd=1 imm=2048 (check enabled) -> out_inst=0x80000093, out_err=1, err_cnt 0->1; BRANCH imm=3 -> out_err=1.
- Back-to-back 8 requests with out_ready toggling 1,0,0,1,...: every word delivered once, in order, out_inst stable during stalls, in_ready=0 while both stages full.
- 300 consecutive erroring requests -> err_cnt saturates at 255.
- Assert rst with both stages full -> out_valid=0 immediately, no stale word after release; first new request appears 2 cycles after acceptance.
